// File: rtl/serial_fs_nb.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one full-subtractor cell
// reused over N cycles, LSB first, with a start/ready/done handshake.
module serial_fs_nb #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_d;
  logic [N-1:0]  diff_q;
  logic          br_q;
  logic          br_d;
  logic          d_bit;
  logic          done_q;
  logic          borrow_q;

  assign d_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

  // New difference bit enters from the MSB side so bit 0 lands in place after N shifts.
  generate
    if (N == 1) begin : g_one
      assign res_d = d_bit;
    end else begin : g_multi
      assign res_d = {d_bit, res_q[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            diff_q   <= res_d;
            borrow_q <= br_d;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
